load_unit: RTL and testbench

Multi-cycle data-memory reader for the MIPS CPU datapath. It is the read side of the data memory, which performs word and rotated stores (`swrr`). The block accepts one load request at a time and fetches one or two words from a synchronous-read memory port. It extracts, aligns and sign- or zero-extends the result, then returns it over a valid/ready response channel. Among its loads is `lwrr`, which exactly undoes the rotation applied by `swrr`.

---
 rtl/load_unit_pkg.sv | 34 +++
 rtl/load_unit_if.sv | 28 ++
 rtl/load_unit_align.sv | 49 ++++
 rtl/load_unit.sv | 121 ++++++++++++
 tb/tb_load_unit.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/load_unit_pkg.sv
// Shared definitions for the data-memory read path: opcodes, FSM encoding and
// the byte-lane rotate used by both swrr (store) and lwrr (load).
package load_unit_pkg;

  localparam logic [2:0] OP_LW   = 3'd0;
  localparam logic [2:0] OP_LH   = 3'd1;
  localparam logic [2:0] OP_LHU  = 3'd2;
  localparam logic [2:0] OP_LB   = 3'd3;
  localparam logic [2:0] OP_LBU  = 3'd4;
  localparam logic [2:0] OP_LWRR = 3'd5;
  localparam logic [2:0] OP_LWU  = 3'd6;
  localparam logic [2:0] OP_RSV  = 3'd7;

  typedef enum logic [2:0] {
    StIdle,
    StRd0,
    StRd1,
    StCap,
    StResp
  } state_e;

  // Rotate left by n bytes; swrr's right rotation is rotl_bytes(w, -n).
  function automatic logic [31:0] rotl_bytes(input logic [31:0] w, input logic [1:0] n);
    logic [31:0] r;
    case (n)
      2'd0:    r = w;
      2'd1:    r = {w[23:0], w[31:24]};
      2'd2:    r = {w[15:0], w[31:16]};
      default: r = {w[7:0], w[31:8]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_unit_if.sv
// Request, response and memory-port signals of the load unit.
interface load_unit_if #(
  parameter int unsigned ADDR_W = 10
) ();
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic [2:0]        req_op;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic              rsp_err;

  // Load unit side.
  modport slave (
    input  req_valid, req_addr, req_op, mem_rdata, rsp_ready,
    output req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_err
  );

  // Requester / memory side.
  modport master (
    output req_valid, req_addr, req_op, mem_rdata, rsp_ready,
    input  req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/load_unit_align.sv
// Combinational extract/align/extend of the fetched word(s) for each load opcode.
module load_align
  import load_unit_pkg::*;
(
  input  logic [31:0] w0_i,
  input  logic [31:0] w1_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  op_i,
  output logic [31:0] data_o,
  output logic        err_o
);

  logic [63:0] pair;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] unaligned;

  assign pair      = {w1_i, w0_i};
  assign byte_sel  = 8'(w0_i >> {off_i, 3'b000});
  assign half_sel  = off_i[1] ? w0_i[31:16] : w0_i[15:0];
  assign unaligned = 32'(pair >> {off_i, 3'b000});

  // Select the result per opcode; errors force zero data.
  always_comb begin
    data_o = '0;
    err_o  = 1'b0;
    case (op_i)
      OP_LW: begin
        err_o  = (off_i != 2'b00);
        data_o = w0_i;
      end
      OP_LH: begin
        err_o  = off_i[0];
        data_o = {{16{half_sel[15]}}, half_sel};
      end
      OP_LHU: begin
        err_o  = off_i[0];
        data_o = {16'h0000, half_sel};
      end
      OP_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  data_o = {24'h000000, byte_sel};
      OP_LWRR: data_o = rotl_bytes(w0_i, off_i);
      OP_LWU:  data_o = unaligned;
      default: err_o  = 1'b1;
    endcase
    if (err_o) data_o = '0;
  end

endmodule

// File: rtl/load_unit.sv
// Multi-cycle data-memory reader: one outstanding load, one or two word reads,
// result returned over a valid/ready response channel.
module load_unit
  import load_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic     CLK,
  input  logic     Reset,
  load_unit_if.slave bus
);

  state_e            state_q;
  logic [ADDR_W+1:0] addr_q;
  logic [2:0]        op_q;
  logic [31:0]       w0_q;
  logic [31:0]       rsp_data_q;
  logic              rsp_err_q;
  logic              rsp_valid_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;

  logic [ADDR_W-1:0] idx1;
  logic              two_word;
  logic [2:0]        al_op;
  logic [1:0]        al_off;
  logic [31:0]       al_w0;
  logic [31:0]       al_data;
  logic              al_err;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

  assign idx1     = addr_q[ADDR_W+1:2] + 1'b1;
  assign two_word = (op_q == OP_LWU) && (addr_q[1:0] != 2'b00);

  // In IDLE the aligner only decides the error from the incoming request.
  assign al_op  = (state_q == StIdle) ? bus.req_op : op_q;
  assign al_off = (state_q == StIdle) ? bus.req_addr[1:0] : addr_q[1:0];
  assign al_w0  = two_word ? w0_q : bus.mem_rdata;

  load_align u_align (
    .w0_i   (al_w0),
    .w1_i   (bus.mem_rdata),
    .off_i  (al_off),
    .op_i   (al_op),
    .data_o (al_data),
    .err_o  (al_err)
  );

  assign bus.req_ready = (state_q == StIdle) && Reset;
  assign bus.mem_rd_en = rd_en_q;
  assign bus.mem_addr  = rd_addr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

  // Load FSM with registered read strobe, read index and response.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      op_q        <= OP_LW;
      w0_q        <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            addr_q <= bus.req_addr[ADDR_W+1:0];
            op_q   <= bus.req_op;
            if (al_err) begin
              rsp_data_q  <= '0;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= StResp;
            end else begin
              rd_en_q   <= 1'b1;
              rd_addr_q <= bus.req_addr[ADDR_W+1:2];
              state_q   <= StRd0;
            end
          end
        end
        StRd0: begin
          if (two_word) begin
            rd_addr_q <= idx1;
            state_q   <= StRd1;
          end else begin
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            state_q   <= StCap;
          end
        end
        StRd1: begin
          w0_q      <= bus.mem_rdata;
          rd_en_q   <= 1'b0;
          rd_addr_q <= '0;
          state_q   <= StCap;
        end
        StCap: begin
          rsp_data_q  <= al_data;
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= StResp;
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// Scoreboard bench for load_unit: stimulus pushes expected responses, a negedge
// monitor pops and compares data, error, latency and memory-read pattern.
module tb_load_unit;
  import load_unit_pkg::*;

  localparam int unsigned AW = 10;

  logic CLK = 1'b0;
  logic Reset = 1'b1;
  always #5 CLK = ~CLK;

  load_unit_if #(.ADDR_W(AW)) bus ();

  load_unit #(.ADDR_W(AW)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  // Synchronous-read memory model.
  logic [31:0] mem [1024];
  always @(posedge CLK) if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        err;
    int          lat;
    int          nrd;
    logic [9:0]  a0;
    logic [9:0]  a1;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor state.
  bit          outstanding = 0;
  bit          in_rsp = 0;
  int          acc_cyc = 0;
  int          lat_seen = 0;
  int          nrd = 0;
  logic [9:0]  rd_addr [2];
  logic [31:0] first_data;
  logic        first_err;

  always @(negedge CLK) begin
    if (!Reset) begin
      outstanding = 0;
      in_rsp = 0;
      nrd = 0;
    end else begin
      if (bus.mem_rd_en) begin
        if (nrd < 2) rd_addr[nrd] = bus.mem_addr;
        nrd++;
      end
      if (bus.rsp_valid) begin
        check("req_ready_busy", 32'(bus.req_ready), 32'd0);
        if (!in_rsp) begin
          in_rsp = 1;
          first_data = bus.rsp_data;
          first_err = bus.rsp_err;
          lat_seen = cyc - acc_cyc;
        end else begin
          check("stable_data", bus.rsp_data, first_data);
          check("stable_err", 32'(bus.rsp_err), 32'(first_err));
        end
        if (bus.rsp_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp: got data %h with no request pending", bus.rsp_data);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, "_data"}, bus.rsp_data, e.data);
            check({e.name, "_err"}, 32'(bus.rsp_err), 32'(e.err));
            check({e.name, "_lat"}, 32'(lat_seen), 32'(e.lat));
            check({e.name, "_nrd"}, 32'(nrd), 32'(e.nrd));
            if (e.nrd > 0) check({e.name, "_idx0"}, 32'(rd_addr[0]), 32'(e.a0));
            if (e.nrd > 1) check({e.name, "_idx1"}, 32'(rd_addr[1]), 32'(e.a1));
          end
          outstanding = 0;
          in_rsp = 0;
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        check("accept_only_idle", 32'(outstanding), 32'd0);
        outstanding = 1;
        acc_cyc = cyc;
        nrd = 0;
      end
    end
  end

  task automatic issue(input string nm, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] d, input logic err, input int lat, input int nr,
                       input logic [9:0] a0, input logic [9:0] a1, input bit hold);
    exp_t e;
    int n;
    e.name = nm; e.data = d; e.err = err; e.lat = lat; e.nrd = nr; e.a0 = a0; e.a1 = a1;
    exp_q.push_back(e);
    bus.req_op = op;
    bus.req_addr = a;
    bus.req_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge CLK);
      if (bus.req_ready) break;
      n++;
      if (n > 50) begin
        $display("FAIL %s_accept: got no req_ready within 50 cycles, expected acceptance", nm);
        $fatal(1, "accept timeout");
      end
    end
    @(posedge CLK);
    #2;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d responses pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge CLK);
    #2;
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    check({nm, "_rd_en"}, 32'(bus.mem_rd_en), 32'd0);
    check({nm, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    check({nm, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({nm, "_rsp_data"}, bus.rsp_data, 32'd0);
    check({nm, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    bus.req_valid = 1'b0;
    bus.req_op = 3'd0;
    bus.req_addr = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[4] = 32'h11223344;
    mem[5] = 32'hAABBCCDD;
    mem[1023] = 32'h01020304;
    mem[0] = 32'h05060708;

    #1 Reset = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) @(posedge CLK);
    #2 Reset = 1'b1;
    @(negedge CLK);
    check("reset_req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge CLK);
    #2;

    issue("lw_10",    OP_LW,   32'h10,  32'h11223344, 0, 3, 1, 10'd4, 10'd0, 0);
    issue("lb_13",    OP_LB,   32'h13,  32'h00000011, 0, 3, 1, 10'd4, 10'd0, 0);
    issue("lb_16",    OP_LB,   32'h16,  32'hFFFFFFBB, 0, 3, 1, 10'd5, 10'd0, 0);
    issue("lbu_16",   OP_LBU,  32'h16,  32'h000000BB, 0, 3, 1, 10'd5, 10'd0, 0);
    issue("lh_12",    OP_LH,   32'h12,  32'h00001122, 0, 3, 1, 10'd4, 10'd0, 0);
    issue("lhu_16",   OP_LHU,  32'h16,  32'h0000AABB, 0, 3, 1, 10'd5, 10'd0, 0);
    issue("lh_11",    OP_LH,   32'h11,  32'h00000000, 1, 1, 0, 10'd0, 10'd0, 0);
    issue("lw_12",    OP_LW,   32'h12,  32'h00000000, 1, 1, 0, 10'd0, 10'd0, 0);
    issue("op7",      OP_RSV,  32'h10,  32'h00000000, 1, 1, 0, 10'd0, 10'd0, 0);
    issue("lwu_12",   OP_LWU,  32'h12,  32'hCCDD1122, 0, 4, 2, 10'd4, 10'd5, 0);
    issue("lwu_ffe",  OP_LWU,  32'hFFE, 32'h07080102, 0, 4, 2, 10'd1023, 10'd0, 0);
    issue("lwu_10",   OP_LWU,  32'h10,  32'h11223344, 0, 3, 1, 10'd4, 10'd0, 0);
    issue("lwrr_11",  OP_LWRR, 32'h11,  32'h22334411, 0, 3, 1, 10'd4, 10'd0, 0);
    issue("lwrr_13",  OP_LWRR, 32'h13,  32'h44112233, 0, 3, 1, 10'd4, 10'd0, 0);
    issue("lw_hiaddr", OP_LW,  32'hFFFFF014, 32'hAABBCCDD, 0, 3, 1, 10'd5, 10'd0, 0);
    drain();

    // swrr of 0x11223344 at A=1 stores the word rotated right by one byte.
    w = 32'h11223344;
    mem[0] = {w[7:0], w[31:8]};
    issue("lwrr_rt",  OP_LWRR, 32'h1,   32'h11223344, 0, 3, 1, 10'd0, 10'd0, 0);
    drain();

    // Backpressure: response held for several cycles.
    bus.rsp_ready = 1'b0;
    issue("lw_bp",    OP_LW,   32'h14,  32'hAABBCCDD, 0, 3, 1, 10'd5, 10'd0, 0);
    repeat (8) @(posedge CLK);
    #2 bus.rsp_ready = 1'b1;
    drain();

    // Back-to-back with req_valid held high.
    issue("b2b_lb",   OP_LB,   32'h10,  32'h00000044, 0, 3, 1, 10'd4, 10'd0, 1);
    issue("b2b_lhu",  OP_LHU,  32'h14,  32'h0000CCDD, 0, 3, 1, 10'd5, 10'd0, 1);
    issue("b2b_lwu",  OP_LWU,  32'h13,  32'hBBCCDD11, 0, 4, 2, 10'd4, 10'd5, 0);
    drain();

    // Reset during RD1 drops the request.
    issue("dropped",  OP_LWU,  32'h12,  32'hCCDD1122, 0, 4, 2, 10'd4, 10'd5, 0);
    @(posedge CLK);
    #2 Reset = 1'b0;
    #1 check_all_zero("midreset");
    void'(exp_q.pop_back());
    repeat (2) @(posedge CLK);
    #2 Reset = 1'b1;
    repeat (3) @(posedge CLK);
    #2;
    issue("lw_after", OP_LW,   32'h14,  32'hAABBCCDD, 0, 3, 1, 10'd5, 10'd0, 0);
    drain();
    repeat (3) @(posedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
